// File: rtl/brnch_predictor.sv
// Purpose : 2-bit saturating-counter branch predictor with mispredict flag and counter.
// Latency : prediction is combinational (0 cycles); table/mispredict/count update on the next rising edge.
// Backpr. : none -- a prediction is always driven and every update is accepted.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pred_pc / pred_taken fetch-side query and its taken guess (from table state)
//   upd_valid, upd_pc,   resolved conditional branch: PC, actual outcome and the
//   upd_taken, upd_pred  prediction originally made for it
//   mispredict          registered one-cycle pulse per wrong resolution
//   mispred_cnt         16-bit saturating mispredict count
// Optional: define BRNCH_PRED_GSHARE_EN to XOR a global history register into the index.
module brnch_predictor #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_pred,
  output logic            mispredict,
  output logic [15:0]     mispred_cnt
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]       r_tbl [DEPTH];
  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [1:0]       w_cur;
  logic [1:0]       w_nxt;
  logic             w_mis;
  logic             r_mispredict;
  logic [15:0]      r_mispred_cnt;

  // Instructions are 2-byte aligned, so bit 0 and the bits above the index never
  // select an entry; PCs that differ only there share a counter.
  logic w_unused_bits;
  assign w_unused_bits = ^{pred_pc[PC_W-1:IDX_W+1], pred_pc[0],
                           upd_pc[PC_W-1:IDX_W+1], upd_pc[0]};

`ifdef BRNCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // The update index uses the current history, not the fetch-time one.
  assign w_pred_idx = pred_pc[IDX_W:1] ^ r_ghr;
  assign w_upd_idx  = upd_pc[IDX_W:1]  ^ r_ghr;

  // Shifts on the same edge as the table write, so that write sees the old history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
    end
  end
`else
  assign w_pred_idx = pred_pc[IDX_W:1];
  assign w_upd_idx  = upd_pc[IDX_W:1];
`endif

  // No bypass: a same-cycle update to the queried entry shows up next cycle.
  assign pred_taken = r_tbl[w_pred_idx][1];

  assign w_cur = r_tbl[w_upd_idx];

  always_comb begin
    w_nxt = w_cur;
    if (upd_taken) begin
      if (w_cur != 2'b11) w_nxt = w_cur + 2'b01;
    end else begin
      if (w_cur != 2'b00) w_nxt = w_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      r_tbl[w_upd_idx] <= w_nxt;
    end
  end

  assign w_mis = upd_valid & (upd_taken ^ upd_pred);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict  <= 1'b0;
      r_mispred_cnt <= 16'h0000;
    end else begin
      r_mispredict <= w_mis;
      if (w_mis && (r_mispred_cnt != 16'hFFFF)) begin
        r_mispred_cnt <= r_mispred_cnt + 16'h0001;
      end
    end
  end

  assign mispredict  = r_mispredict;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_brnch_predictor.sv
// Purpose : randomized + directed bench for brnch_predictor against a behavioural model.
// Latency : driver applies one stimulus per cycle; monitor checks at the following falling edge.
// Backpr. : none; expectations flow through a queue from driver to monitor.
module tb_brnch_predictor;

  localparam int IDX_W = 4;
  localparam int PC_W  = 16;
  localparam int DEPTH = 2 ** IDX_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PC_W-1:0] pred_pc = '0;
  logic            pred_taken;
  logic            upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic            upd_pred = 1'b0;
  logic            mispredict;
  logic [15:0]     mispred_cnt;

  brnch_predictor #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mispredict(mispredict), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit      pred;
    bit      mis;
    int      cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: plain integer counters and history.
  int m_tbl [DEPTH];
  int m_ghr;
  bit m_mis;
  int m_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input int pc);
    int i;
    i = (pc / 2) % DEPTH;
`ifdef BRNCH_PRED_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
    m_ghr = 0;
    m_mis = 0;
    m_cnt = 0;
  endtask

  // One clock of stimulus: expected outputs for this cycle go to the queue,
  // then the model advances to what the coming edge should produce.
  task automatic cyc(input int ppc, input bit uv, input int upc, input bit ut, input bit up);
    exp_t e;
    int   i;
    @(posedge clk);
    #1;
    pred_pc   = ppc[PC_W-1:0];
    upd_valid = uv;
    upd_pc    = upc[PC_W-1:0];
    upd_taken = ut;
    upd_pred  = up;
    e.pred = (m_tbl[idx_of(ppc)] >= 2);
    e.mis  = m_mis;
    e.cnt  = m_cnt;
    q.push_back(e);
    if (uv) begin
      i = idx_of(upc);
      m_tbl[i] = ut ? ((m_tbl[i] == 3) ? 3 : m_tbl[i] + 1)
                    : ((m_tbl[i] == 0) ? 0 : m_tbl[i] - 1);
      m_ghr = ((m_ghr * 2) + (ut ? 1 : 0)) % DEPTH;
    end
    m_mis = uv && (ut != up);
    if (m_mis && m_cnt < 65535) m_cnt++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pred_taken",  int'(pred_taken),  int'(e.pred));
      chk("mispredict",  int'(mispredict),  int'(e.mis));
      chk("mispred_cnt", int'(mispred_cnt), e.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state across every index.
    for (int pc = 0; pc <= 'h1E; pc += 2) cyc(pc, 0, 0, 0, 0);

    // Two mispredicted taken updates on 0x0004.
    cyc('h4, 1, 'h4, 1, 0);
    cyc('h4, 1, 'h4, 1, 0);
    cyc('h4, 0, 0, 0, 0);
    cyc('h4, 0, 0, 0, 0);

    // Saturation up and down on 0x0008.
    for (int k = 0; k < 5; k++) cyc('h8, 1, 'h8, 1, 1);
    for (int k = 0; k < 6; k++) cyc('h8, 1, 'h8, 0, 0);
    for (int k = 0; k < 3; k++) cyc('h8, 1, 'h8, 1, 0);
    cyc('h8, 0, 0, 0, 0);

    // Same-cycle predict and update to one entry (still at weak-NT).
    cyc('hC, 1, 'hC, 1, 0);
    cyc('hC, 0, 0, 0, 0);

    // Aliasing: 0x0002 and 0x0022 share a counter.
    cyc('h22, 1, 'h2, 1, 1);
    cyc('h22, 1, 'h2, 1, 1);
    cyc('h22, 0, 0, 0, 0);

    // Random traffic over a small PC window to exercise aliasing and saturation.
    for (int k = 0; k < 400; k++) begin
      cyc(int'($urandom_range(0, 'h3F)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 'h3F)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)));
    end

    // Drive the count past its ceiling.
    for (int k = 0; k < 65540; k++) cyc('h10, 1, 'h10, k[0], ~k[0]);

    // Mid-cycle asynchronous reset while mispredict is high and the count is saturated.
    @(negedge clk);
    #1;
    chk("sat_mispredict",  int'(mispredict),  int'(m_mis));
    chk("sat_mispred_cnt", int'(mispred_cnt), m_cnt);
    #1 rst_n = 1'b0;
    upd_valid = 1'b0;
    #1;
    chk("arst_mispredict",  int'(mispredict),  0);
    chk("arst_mispred_cnt", int'(mispred_cnt), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table must be back at weak-NT everywhere.
    for (int pc = 0; pc <= 'h1E; pc += 2) cyc(pc, 0, 0, 0, 0);
    cyc('h6, 1, 'h6, 1, 0);
    cyc('h6, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brnch_predictor.md
Name: brnch_predictor

Overview:
- Dynamic branch predictor for the pipelined WiscSP13 core: table of 2-bit saturating counters indexed by fetch PC.
- The fetch stage queries it for a taken/not-taken guess.
- brnch_checker's resolved branch_sel is fed back as the update; the block flags mispredicts and keeps a statistics count.
- It sits at the opposite end of the branch-decision interface from the checker: it predicts, the checker resolves.

Parameters:
- IDX_W, 4, index width; table depth = 2^IDX_W entries.
- PC_W, 16, PC width; instructions are 2-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pred_pc  input  PC_W  PC of the instruction being fetched.
- pred_taken  output  1  prediction for pred_pc, combinational from table state.
- upd_valid  input  1  a conditional branch resolved this cycle.
- upd_pc  input  PC_W  PC of the resolved branch.
- upd_taken  input  1  actual outcome (brnch_checker branch_sel).
- upd_pred  input  1  prediction originally made for that branch, carried down the pipe.
- mispredict  output  1  registered pulse, one cycle after a wrong prediction resolves.
- mispred_cnt  output  16  saturating count of mispredicts.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Storage: 2^IDX_W entries, 2 bits each.
  - On rst_n low, every entry is set asynchronously to 2'b01 (weakly not-taken).
- Index: idx = pc[IDX_W:1]; bit 0 is ignored.
- Predict path (0-cycle latency): pred_taken = table[idx(pred_pc)][1]. No pred_valid; the output is always driven.
- Update, at posedge when upd_valid = 1, on entry e = table[idx(upd_pc)]:
  - upd_taken = 1: e <= (e == 3) ? 3 : e + 1.
  - upd_taken = 0: e <= (e == 0) ? 0 : e - 1.
  - upd_valid = 0: table unchanged.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. No wrap in either direction.
- Simultaneous predict and update to the same index: pred_taken reflects the pre-update value. The new value is visible the cycle after the edge; there is no bypass.
- mispredict:
  - Register, reset 0.
  - Each edge it loads upd_valid & (upd_taken ^ upd_pred), so it is a one-cycle pulse per wrong resolution.
  - Back-to-back mispredicts give back-to-back high cycles.
- mispred_cnt:
  - 16-bit register, reset 16'h0000.
  - Increments on the same condition that sets mispredict, in the same cycle mispredict is loaded.
  - Holds at 16'hFFFF; no wrap.
- Reset mid-operation: asynchronous clear of table, mispredict, mispred_cnt and (if present) history. An update on the same edge that reset releases is dropped.
- Aliased PCs with equal index bits share one counter. This is intended.

Optional Feature:
- Macro: BRNCH_PRED_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register ghr, reset 0.
  - Both predict and update index use pc[IDX_W:1] ^ ghr.
  - On each upd_valid edge, ghr <= {ghr[IDX_W-2:0], upd_taken}, taking effect after the table write, which uses the old ghr.
  - The update index uses the current ghr, not a snapshot from fetch time; this is accepted as a known approximation.
- Undefined: no ghr exists, and the index is pc[IDX_W:1] only.

Test Plan:
- Reset, then pred_pc = 16'h0000 through 16'h001E: pred_taken = 0 for all; mispredict = 0; mispred_cnt = 0.
- Two updates pc = 16'h0004, taken = 1, pred = 0:
  - pred_taken(16'h0004) becomes 1 after the first update.
  - mispredict pulses on both edges+1.
  - mispred_cnt = 2.
- Saturation: 5 taken updates on 16'h0008, then 1 not-taken: prediction stays 1 (3->2). A second not-taken gives 0 (2->1). 4 more not-taken hold the counter at 0 (checked via 2 taken needed to flip).
- Same-cycle collision: pred_pc = upd_pc = 16'h000C, upd_taken = 1, entry at 1: pred_taken = 0 that cycle, 1 the next cycle.
- Alias: update pc 16'h0002 taken twice: pred_taken(16'h0022) = 1 with IDX_W = 4 (GSHARE undefined).
- Counter saturation and reset: force 65,540 mispredicts: mispred_cnt = 16'hFFFF. Assert rst_n low mid-cycle: the count and mispredict clear immediately, without waiting for a clock edge.
